uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_ctrl_if.sv | 38 +++
 rtl/uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if -- link between the RX sequencing controller and the
// receiver / RX FIFO.
//
// Signals:
//   enable        16x baud tick to the receiver
//   rf_pop        pop one entry from the RX FIFO
//   rx_reset      clear the RX FIFO
//   lsr_mask      clear the FIFO error status
//   rf_count      RX FIFO occupancy
//   rf_overrun    RX FIFO overrun
//   rf_error_bit  an error-flagged character is in the FIFO
//   counter_t     receiver character-timeout counter
//
// Modports:
//   master  controller side (drives enable/rf_pop/rx_reset/lsr_mask)
//   slave   receiver side (drives FIFO status and timeout counter)
interface uart_rx_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             enable;
  logic             rf_pop;
  logic             rx_reset;
  logic             lsr_mask;
  logic [CNT_W-1:0] rf_count;
  logic             rf_overrun;
  logic             rf_error_bit;
  logic [9:0]       counter_t;

  modport master (
    output enable, rf_pop, rx_reset, lsr_mask,
    input  rf_count, rf_overrun, rf_error_bit, counter_t
  );

  modport slave (
    input  enable, rf_pop, rx_reset, lsr_mask,
    output rf_count, rf_overrun, rf_error_bit, counter_t
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- sequencing and interrupt controller for the UART receive
// path. Generates the 16x baud tick, sequences RX FIFO clears, turns host
// RBR reads into FIFO pops, keeps line-status bits and raises the
// data-available, character-timeout and line-status interrupts.
//
// Parameters:
//   DL_W    divisor latch width
//   CNT_W   FIFO count width
//   SETTLE  idle cycles after a FIFO clear before pops/interrupts resume (1..7)
//
// Ports:
//   clk, wb_rst_i       clock, synchronous active-high reset
//   dl, dl_load         baud divisor and its write pulse
//   fcr_trig            RX trigger level select (00:1 01:4 10:8 11:14)
//   fcr_rx_clr          clear-RX-FIFO pulse
//   ier_rda, ier_rls    interrupt enables
//   rbr_rd, lsr_rd      host read pulses
//   rx                  uart_rx_ctrl_if.master link to receiver / FIFO
//   rda_int, ti_int,
//   rls_int             receive interrupts
//   lsr_oe, lsr_fe      sticky overrun, FIFO error flag
//   dma_rx_req          DMA request (only with UART_RX_CTRL_DMA_EN defined)
//
// Optional feature macro: UART_RX_CTRL_DMA_EN
module uart_rx_ctrl #(
  parameter int DL_W   = 16,
  parameter int CNT_W  = 5,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  input  logic [DL_W-1:0] dl,
  input  logic            dl_load,
  input  logic [1:0]      fcr_trig,
  input  logic            fcr_rx_clr,
  input  logic            ier_rda,
  input  logic            ier_rls,
  input  logic            rbr_rd,
  input  logic            lsr_rd,
  uart_rx_ctrl_if.master  rx,
  output logic            rda_int,
  output logic            ti_int,
  output logic            rls_int,
  output logic            lsr_oe,
  output logic            lsr_fe
`ifdef UART_RX_CTRL_DMA_EN
  ,
  output logic            dma_rx_req
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLR    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      settle_cnt;
  logic [DL_W-1:0] dlc;
  logic            idle;
  logic            fifo_nonempty;
  logic            pop_req;

  logic enable_p0;
  logic pop_p0;
  logic rda_p0;
  logic ti_p0;
  logic oe_p0;
  logic fe_p0;
  logic mask_p0;
  logic rls_p0;
`ifdef UART_RX_CTRL_DMA_EN
  logic dma_p0;
`endif

  function automatic logic [CNT_W-1:0] trig_level(input logic [1:0] sel);
    case (sel)
      2'b00:   trig_level = CNT_W'(1);
      2'b01:   trig_level = CNT_W'(4);
      2'b10:   trig_level = CNT_W'(8);
      default: trig_level = CNT_W'(14);
    endcase
  endfunction

  always_comb begin
    idle          = (state == ST_IDLE);
    fifo_nonempty = (rx.rf_count != '0);
    // A pop is only accepted while idle and only if the FIFO holds data now.
    pop_req       = idle && rbr_rd && fifo_nonempty;
  end

  // ---- baud divisor: one registered tick every dl clocks ----
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      dlc       <= '0;
      enable_p0 <= 1'b0;
    end else if (dl == '0) begin
      dlc       <= '0;
      enable_p0 <= 1'b0;
    end else if (dl_load) begin
      dlc       <= dl - DL_W'(1);
      enable_p0 <= 1'b0;
    end else if (dlc == '0) begin
      dlc       <= dl - DL_W'(1);
      enable_p0 <= 1'b1;
    end else begin
      dlc       <= dlc - DL_W'(1);
      enable_p0 <= 1'b0;
    end
  end

  // ---- clear-sequence FSM: state register ----
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLR) begin
        settle_cnt <= 3'(SETTLE);
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - 3'd1;
      end
    end
  end

  // ---- clear-sequence FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fcr_rx_clr) state_nxt = ST_CLR;
      end
      ST_CLR: begin
        state_nxt = fcr_rx_clr ? ST_CLR : ST_SETTLE;
      end
      ST_SETTLE: begin
        // Counter reaches zero on this edge.
        if (fcr_rx_clr)              state_nxt = ST_CLR;
        else if (settle_cnt <= 3'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- pop / interrupt / line-status registers ----
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      pop_p0  <= 1'b0;
      rda_p0  <= 1'b0;
      ti_p0   <= 1'b0;
      oe_p0   <= 1'b0;
      fe_p0   <= 1'b0;
      mask_p0 <= 1'b0;
      rls_p0  <= 1'b0;
    end else begin
      pop_p0 <= pop_req;
      rda_p0 <= ier_rda && idle && (rx.rf_count >= trig_level(fcr_trig));

      // Clear (pop, disable, clear request) beats set in the same cycle.
      if (pop_req || !ier_rda || fcr_rx_clr) begin
        ti_p0 <= 1'b0;
      end else if (ier_rda && idle && (rx.counter_t == '0) && fifo_nonempty) begin
        ti_p0 <= 1'b1;
      end

      // Overrun beats a simultaneous LSR read; a FIFO clear wipes it.
      if (fcr_rx_clr || !idle) begin
        oe_p0 <= 1'b0;
      end else if (rx.rf_overrun) begin
        oe_p0 <= 1'b1;
      end else if (lsr_rd) begin
        oe_p0 <= 1'b0;
      end

      fe_p0   <= rx.rf_error_bit;
      mask_p0 <= lsr_rd;
      rls_p0  <= ier_rls && (oe_p0 || fe_p0);
    end
  end

`ifdef UART_RX_CTRL_DMA_EN
  // ---- DMA request: low on the pop cycle and the cycle after ----
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      dma_p0 <= 1'b0;
    end else begin
      dma_p0 <= !pop_req && !pop_p0 && idle && fifo_nonempty &&
                ((rx.rf_count >= trig_level(fcr_trig)) || (rx.counter_t == '0));
    end
  end
`endif

  // ---- clear-sequence FSM: outputs ----
  // Registered pop and data interrupts are masked while a clear is in
  // progress, so a request captured on the clear edge never leaks out.
  always_comb begin
    rx.enable   = enable_p0;
    rx.rx_reset = (state == ST_CLR);
    rx.rf_pop   = pop_p0 && idle;
    rx.lsr_mask = mask_p0;
    rda_int     = rda_p0 && idle;
    ti_int      = ti_p0 && idle;
    rls_int     = rls_p0;
    lsr_oe      = oe_p0;
    lsr_fe      = fe_p0;
`ifdef UART_RX_CTRL_DMA_EN
    dma_rx_req  = dma_p0;
`endif
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed stimulus pushes hand-computed
// expectations (cycle, output bit, value) into a scoreboard queue; a
// monitor on the falling edge compares every entry due in that cycle.
module tb_uart_rx_ctrl;

  localparam int B_EN   = 8;
  localparam int B_POP  = 7;
  localparam int B_RST  = 6;
  localparam int B_MASK = 5;
  localparam int B_RDA  = 4;
  localparam int B_TI   = 3;
  localparam int B_RLS  = 2;
  localparam int B_OE   = 1;
  localparam int B_FE   = 0;

  logic        clk;
  logic        wb_rst_i;
  logic [15:0] dl;
  logic        dl_load;
  logic [1:0]  fcr_trig;
  logic        fcr_rx_clr;
  logic        ier_rda;
  logic        ier_rls;
  logic        rbr_rd;
  logic        lsr_rd;
  logic        rda_int;
  logic        ti_int;
  logic        rls_int;
  logic        lsr_oe;
  logic        lsr_fe;
`ifdef UART_RX_CTRL_DMA_EN
  logic        dma_rx_req;
`endif

  uart_rx_ctrl_if #(.CNT_W(5)) rx_bus ();

  uart_rx_ctrl #(.DL_W(16), .CNT_W(5), .SETTLE(2)) dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .dl         (dl),
    .dl_load    (dl_load),
    .fcr_trig   (fcr_trig),
    .fcr_rx_clr (fcr_rx_clr),
    .ier_rda    (ier_rda),
    .ier_rls    (ier_rls),
    .rbr_rd     (rbr_rd),
    .lsr_rd     (lsr_rd),
    .rx         (rx_bus),
    .rda_int    (rda_int),
    .ti_int     (ti_int),
    .rls_int    (rls_int),
    .lsr_oe     (lsr_oe),
    .lsr_fe     (lsr_fe)
`ifdef UART_RX_CTRL_DMA_EN
    ,
    .dma_rx_req (dma_rx_req)
`endif
  );

  typedef struct {
    string nm;
    int    cyc;
    int    b;
    logic  v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int dly, input int b, input logic v);
    exp_t e;
    e.nm  = nm;
    e.cyc = cyc + dly;
    e.b   = b;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk_all0(input string nm, input int dly);
    for (int b = 0; b < 9; b++) chk(nm, dly, b, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] obs;
    obs = {rx_bus.enable, rx_bus.rf_pop, rx_bus.rx_reset, rx_bus.lsr_mask,
           rda_int, ti_int, rls_int, lsr_oe, lsr_fe};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_cmp = n_cmp + 1;
        if (q[i].cyc < cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL %s (bit %0d) missed: due cycle %0d, now %0d",
                   q[i].nm, q[i].b, q[i].cyc, cyc);
        end else if (obs[q[i].b] !== q[i].v) begin
          n_bad = n_bad + 1;
          $display("FAIL %s (bit %0d) cycle %0d: got %b, expected %b",
                   q[i].nm, q[i].b, cyc, obs[q[i].b], q[i].v);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i             = 1'b1;
    dl                   = '0;
    dl_load              = 1'b0;
    fcr_trig             = 2'b00;
    fcr_rx_clr           = 1'b0;
    ier_rda              = 1'b0;
    ier_rls              = 1'b0;
    rbr_rd               = 1'b0;
    lsr_rd               = 1'b0;
    rx_bus.rf_count      = '0;
    rx_bus.rf_overrun    = 1'b0;
    rx_bus.rf_error_bit  = 1'b0;
    rx_bus.counter_t     = 10'h3ff;

    // Reset state
    repeat (3) step();
    chk_all0("reset_state", 0);
    wb_rst_i = 1'b0;
    step();

    // Divisor dl=4: ticks 4 clocks after the load is sampled, then every 4
    dl = 16'd4;
    dl_load = 1'b1;
    for (int k = 1; k <= 12; k++) chk("div4_tick", k, B_EN, (k == 5) || (k == 9));
    step();
    dl_load = 1'b0;
    repeat (11) step();
    // dl=0: enable stays low
    dl = '0;
    for (int k = 1; k <= 100; k++) chk("div0_quiet", k, B_EN, 1'b0);
    repeat (100) step();

    // Trigger levels
    ier_rda  = 1'b1;
    fcr_trig = 2'b01;
    for (int c = 0; c <= 5; c++) begin
      rx_bus.rf_count = 5'(c);
      chk("rda_trig4", 1, B_RDA, c >= 4);
      step();
    end
    fcr_trig = 2'b10; rx_bus.rf_count = 5'd7;  chk("rda_trig8_c7", 1, B_RDA, 1'b0); step();
    rx_bus.rf_count = 5'd8;                    chk("rda_trig8_c8", 1, B_RDA, 1'b1); step();
    fcr_trig = 2'b11; rx_bus.rf_count = 5'd13; chk("rda_trig14_c13", 1, B_RDA, 1'b0); step();
    rx_bus.rf_count = 5'd16;                   chk("rda_trig14_c16", 1, B_RDA, 1'b1); step();
    fcr_trig = 2'b00; rx_bus.rf_count = 5'd1;  chk("rda_trig1_c1", 1, B_RDA, 1'b1); step();
    ier_rda = 1'b0; rx_bus.rf_count = '0;      chk("rda_off", 1, B_RDA, 1'b0); step();

    // Character timeout and pop
    ier_rda = 1'b1; fcr_trig = 2'b10; rx_bus.rf_count = 5'd2; rx_bus.counter_t = '0;
    chk("ti_set", 1, B_TI, 1'b1);
    step();
    rbr_rd = 1'b1;
    chk("pop_issue", 1, B_POP, 1'b1);
    chk("ti_clr_pop", 1, B_TI, 1'b0);
    chk("pop_single", 2, B_POP, 1'b0);
    chk("ti_reset", 2, B_TI, 1'b1);
    step();
    rbr_rd = 1'b0;
    step();
    ier_rda = 1'b0;
    chk("ti_clr_ier", 1, B_TI, 1'b0);
    step();
    rx_bus.counter_t = 10'h3ff; rx_bus.rf_count = '0; rbr_rd = 1'b1;
    chk("pop_empty", 1, B_POP, 1'b0);
    step();
    rbr_rd = 1'b0;
    step();
    // Held read: one pop per cycle
    rx_bus.rf_count = 5'd3; rbr_rd = 1'b1;
    for (int k = 1; k <= 4; k++) chk("pop_held", k, B_POP, k <= 3);
    repeat (3) step();
    rbr_rd = 1'b0;
    step();
    rx_bus.rf_count = '0;
    step();

    // FIFO clear
    ier_rda = 1'b1; fcr_trig = 2'b10; rx_bus.rf_count = 5'd8;
    chk("rda_pre_clr", 1, B_RDA, 1'b1);
    step();
    fcr_rx_clr = 1'b1;
    for (int k = 1; k <= 4; k++) chk("rx_reset_pulse", k, B_RST, k == 1);
    for (int k = 1; k <= 5; k++) chk("rda_clr_mask", k, B_RDA, k == 5);
    for (int k = 2; k <= 5; k++) chk("pop_clr_ignore", k, B_POP, k == 5);
    step();
    fcr_rx_clr = 1'b0; rbr_rd = 1'b1;
    repeat (4) step();
    rbr_rd = 1'b0; ier_rda = 1'b0; rx_bus.rf_count = '0;
    repeat (2) step();

    // Line status
    ier_rls = 1'b1; rx_bus.rf_overrun = 1'b1; lsr_rd = 1'b1;
    chk("oe_set_prio", 1, B_OE, 1'b1);
    chk("mask_rd1", 1, B_MASK, 1'b1);
    chk("rls_oe", 2, B_RLS, 1'b1);
    chk("mask_rd1_end", 2, B_MASK, 1'b0);
    chk("oe_sticky", 3, B_OE, 1'b1);
    step();
    rx_bus.rf_overrun = 1'b0; lsr_rd = 1'b0;
    repeat (2) step();
    lsr_rd = 1'b1;
    chk("oe_clr_rd", 1, B_OE, 1'b0);
    chk("mask_rd2", 1, B_MASK, 1'b1);
    chk("mask_rd2_end", 2, B_MASK, 1'b0);
    chk("rls_drop", 2, B_RLS, 1'b0);
    step();
    lsr_rd = 1'b0;
    step();
    rx_bus.rf_error_bit = 1'b1;
    chk("fe_set", 1, B_FE, 1'b1);
    chk("rls_fe", 2, B_RLS, 1'b1);
    step();
    rx_bus.rf_error_bit = 1'b0;
    chk("fe_clr", 1, B_FE, 1'b0);
    step();
    ier_rls = 1'b0;
    step();

    // Reset during SETTLE with the divisor running
    dl = 16'd3; dl_load = 1'b1;
    step();
    dl_load = 1'b0;
    repeat (5) step();
    fcr_rx_clr = 1'b1; ier_rda = 1'b1; fcr_trig = 2'b10; rx_bus.rf_count = 5'd8;
    step();
    fcr_rx_clr = 1'b0;
    step();
    wb_rst_i = 1'b1;
    chk_all0("reset_mid_settle", 1);
    step();
    wb_rst_i = 1'b0; dl_load = 1'b1; rbr_rd = 1'b1;
    for (int k = 1; k <= 7; k++) chk("div3_after_rst", k, B_EN, (k == 4) || (k == 7));
    chk("pop_after_rst", 1, B_POP, 1'b1);
    chk("rda_after_rst", 1, B_RDA, 1'b1);
    chk("no_rx_reset_after_rst", 1, B_RST, 1'b0);
    step();
    dl_load = 1'b0; rbr_rd = 1'b0;
    repeat (7) step();

    // Drain the scoreboard
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
